// File: rtl/spi_channel_shifter_if.sv
// Engine/pad-side signal bundle for the per-channel SPI shift datapath.
// The shifter uses the slave modport; the transfer engine (or a bench) uses master.
interface spi_channel_shifter_if #(
    parameter int N_CHANNELS   = 3,
    parameter int OUTPUT_WIDTH = 32
);
    logic                               register_load;
    logic                               register_enable;
    logic [32*N_CHANNELS-1:0]           reg_data_in;
    logic [4:0]                         spi_transfer_length;
    logic                               lsb_first;
    logic                               launch_strobe;
    logic                               capture_strobe;
    logic [N_CHANNELS-1:0]              miso;
    logic [N_CHANNELS-1:0]              mosi;
    logic [OUTPUT_WIDTH*N_CHANNELS-1:0] reg_data_out;
    logic                               reg_data_out_valid;
    logic                               busy;

    modport master (
        output register_load, register_enable, reg_data_in, spi_transfer_length,
        output lsb_first, launch_strobe, capture_strobe, miso,
        input  mosi, reg_data_out, reg_data_out_valid, busy
    );

    modport slave (
        input  register_load, register_enable, reg_data_in, spi_transfer_length,
        input  lsb_first, launch_strobe, capture_strobe, miso,
        output mosi, reg_data_out, reg_data_out_valid, busy
    );
endinterface

// File: rtl/spi_channel_shifter.sv
// Per-channel SPI shift registers: serialise loaded words on MOSI and collect MISO,
// all lanes sharing one FSM driven by launch/capture strobes from the clock generator.
module spi_channel_shifter #(
    parameter int N_CHANNELS   = 3,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_channel_shifter_if.slave bus
);
    localparam logic [4:0] MAX_LEN_M1 = 5'(OUTPUT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SHIFTING,
        S_DONE
    } state_t;

    state_t                                   r_state;
    logic                                     r_busy;
    logic                                     r_valid;
    logic [5:0]                               r_bit_cnt;
    logic [4:0]                               r_len_m1;
    logic                                     r_lsb;
    logic [N_CHANNELS-1:0]                    r_mosi;
    logic [N_CHANNELS-1:0][31:0]              r_tx_sr;
    logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0]  r_rx_sr;
    logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0]  r_data_out;

    logic                                     w_load_ok;
    logic                                     w_abort;
    logic                                     w_active;
    logic                                     w_capture;
    logic                                     w_launch;
    logic                                     w_last;
    logic [4:0]                               w_load_len_m1;
    logic [31:0]                              w_load_mask;
    logic [OUTPUT_WIDTH-1:0]                  w_rx_mask;
    logic [OUTPUT_WIDTH-1:0]                  w_rx_sel;
    logic [N_CHANNELS-1:0]                    w_first_bits;
    logic [N_CHANNELS-1:0]                    w_launch_bits;
    logic [N_CHANNELS-1:0][31:0]              w_tx_load;
    logic [N_CHANNELS-1:0][31:0]              w_tx_shift;
    logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0]  w_rx_next;
    logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0]  w_out_word;

    assign w_load_ok = bus.register_load && bus.register_enable &&
                       (r_state == S_IDLE || r_state == S_ARMED || r_state == S_DONE);
    assign w_abort   = !bus.register_enable && (r_state == S_ARMED || r_state == S_SHIFTING);
    // Strobes count only once the engine has released load; the first one also leaves ARMED.
    assign w_active  = bus.register_enable &&
                       (r_state == S_SHIFTING || (r_state == S_ARMED && !bus.register_load));
    assign w_capture = w_active && bus.capture_strobe;
    assign w_launch  = w_active && bus.launch_strobe;
    assign w_last    = w_capture && (r_bit_cnt == {1'b0, r_len_m1});

    assign w_load_len_m1 = (bus.spi_transfer_length > MAX_LEN_M1) ? MAX_LEN_M1
                                                                  : bus.spi_transfer_length;
    // Masking tx at load makes the shift-in zeros appear on MOSI once the word is exhausted.
    assign w_load_mask   = 32'hFFFF_FFFF >> (5'd31 - w_load_len_m1);
    assign w_rx_mask     = {OUTPUT_WIDTH{1'b1}} >> (MAX_LEN_M1 - r_len_m1);
    assign w_rx_sel      = {{(OUTPUT_WIDTH-1){1'b0}}, 1'b1} << r_bit_cnt;

    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_lane
            assign w_tx_load[gi]    = bus.reg_data_in[gi*32 +: 32] & w_load_mask;
            assign w_first_bits[gi] = bus.lsb_first ? w_tx_load[gi][0]
                                                    : w_tx_load[gi][w_load_len_m1];
            assign w_tx_shift[gi]   = r_lsb ? (r_tx_sr[gi] >> 1) : (r_tx_sr[gi] << 1);
            assign w_launch_bits[gi] = r_lsb ? w_tx_shift[gi][0] : w_tx_shift[gi][r_len_m1];
            assign w_rx_next[gi]    = r_lsb
                ? ((r_rx_sr[gi] & ~w_rx_sel) | (bus.miso[gi] ? w_rx_sel : '0))
                : {r_rx_sr[gi][OUTPUT_WIDTH-2:0], bus.miso[gi]};
            assign w_out_word[gi]   = w_rx_next[gi] & w_rx_mask;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_bit_cnt  <= '0;
            r_len_m1   <= '0;
            r_lsb      <= 1'b0;
            r_mosi     <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_data_out <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_mosi  <= '0;
            end else if (w_load_ok) begin
                r_state   <= S_ARMED;
                r_busy    <= 1'b1;
                r_bit_cnt <= '0;
                r_len_m1  <= w_load_len_m1;
                r_lsb     <= bus.lsb_first;
                r_tx_sr   <= w_tx_load;
                r_rx_sr   <= '0;
                r_mosi    <= w_first_bits;
            end else begin
                case (r_state)
                    S_DONE:  r_state <= S_IDLE;
                    S_ARMED: if (w_capture || w_launch) r_state <= S_SHIFTING;
                    default: ;
                endcase
                if (w_capture) begin
                    r_rx_sr   <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end
                if (w_launch) begin
                    r_tx_sr <= w_tx_shift;
                    r_mosi  <= w_launch_bits;
                end
                // Final capture: publish the word on the same edge so valid lands in DONE.
                if (w_last) begin
                    r_state    <= S_DONE;
                    r_busy     <= 1'b0;
                    r_valid    <= 1'b1;
                    r_data_out <= w_out_word;
                    r_mosi     <= '0;
                end
            end
        end
    end

    assign bus.mosi               = r_mosi;
    assign bus.reg_data_out       = r_data_out;
    assign bus.reg_data_out_valid = r_valid;
    assign bus.busy               = r_busy;

endmodule

// File: tb/tb_spi_channel_shifter.sv
// Scoreboard bench for spi_channel_shifter: expected words are queued at stimulus
// time and compared when the valid pulse appears.
module tb_spi_channel_shifter;
    localparam int N  = 3;
    localparam int OW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int valid_cnt = 0;
    logic [95:0] sb_q[$];
    logic [95:0] mon_exp;
    logic [31:0] mosi_seq;

    always #5 clock = ~clock;

    spi_channel_shifter_if #(.N_CHANNELS(N), .OUTPUT_WIDTH(OW)) bus_if ();

    spi_channel_shifter #(.N_CHANNELS(N), .OUTPUT_WIDTH(OW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        #2;
        if (bus_if.reg_data_out_valid === 1'b1) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 128'(sb_q.size()), 128'(1));
            end else begin
                mon_exp = sb_q.pop_front();
                check("rx_word", 128'(bus_if.reg_data_out), 128'(mon_exp));
                $display("xfer %0d: reg_data_out=%h", valid_cnt, bus_if.reg_data_out);
            end
        end
    end

    // stop_kind: 0 complete, 1 drop enable, 2 assert reset (after stop_at captures)
    task automatic run_xfer(input logic [95:0] data, input logic [4:0] len, input logic lsb,
                            input logic loopback, input logic [31:0] mword, input logic coinc,
                            input int hold, input int stop_at, input int stop_kind);
        int          nbits;
        int          v0;
        logic [31:0] mask;
        logic [31:0] src;
        logic [31:0] tmp;
        logic [95:0] exp_v;
        logic [95:0] prev_out;
        nbits = int'(len) + 1;
        if (nbits > OW) nbits = OW;
        mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        exp_v = '0;
        for (int ch = 0; ch < N; ch++) begin
            src   = loopback ? 32'(data >> (ch*32)) : mword;
            exp_v = exp_v | (96'(src & mask) << (ch*32));
        end
        v0       = valid_cnt;
        prev_out = bus_if.reg_data_out;
        if (stop_kind == 0) sb_q.push_back(exp_v);

        bus_if.reg_data_in         = data;
        bus_if.spi_transfer_length = len;
        bus_if.lsb_first           = lsb;
        bus_if.register_enable     = 1'b1;
        bus_if.register_load       = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus_if.capture_strobe = (h % 2 == 1);
            bus_if.launch_strobe  = (h % 2 == 0);
            tick();
        end
        bus_if.register_load  = 1'b0;
        bus_if.capture_strobe = 1'b0;
        bus_if.launch_strobe  = 1'b0;
        check("busy_armed", 128'(bus_if.busy), 128'(1));

        mosi_seq = '0;
        for (int k = 0; k < ((stop_kind == 0) ? nbits : stop_at); k++) begin
            repeat (3) tick();
            tmp = mword >> (lsb ? k : (nbits - 1 - k));
            bus_if.miso = loopback ? bus_if.mosi : {N{tmp[0]}};
            mosi_seq = mosi_seq | (32'(bus_if.mosi[0]) << k);
            bus_if.capture_strobe = 1'b1;
            bus_if.launch_strobe  = coinc;
            tick();
            bus_if.capture_strobe = 1'b0;
            bus_if.launch_strobe  = 1'b0;
            if (!coinc && k != nbits - 1) begin
                repeat (3) tick();
                bus_if.launch_strobe = 1'b1;
                tick();
                bus_if.launch_strobe = 1'b0;
            end
        end

        if (stop_kind == 0) begin
            check("valid_pulse", 128'(bus_if.reg_data_out_valid), 128'(1));
            check("busy_done", 128'(bus_if.busy), 128'(0));
            check("mosi_done", 128'(bus_if.mosi), 128'(0));
            tick();
            check("valid_clear", 128'(bus_if.reg_data_out_valid), 128'(0));
            check("valid_count", 128'(valid_cnt), 128'(v0 + 1));
        end else begin
            repeat (2) tick();
            if (stop_kind == 1) begin
                bus_if.register_enable = 1'b0;
                tick();
                bus_if.register_enable = 1'b1;
            end else begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            check("busy_stop", 128'(bus_if.busy), 128'(0));
            check("mosi_stop", 128'(bus_if.mosi), 128'(0));
            check("valid_stop", 128'(bus_if.reg_data_out_valid), 128'(0));
            check("out_stop", 128'(bus_if.reg_data_out), (stop_kind == 2) ? 128'(0) : 128'(prev_out));
            repeat (2) tick();
            check("no_valid_stop", 128'(valid_cnt), 128'(v0));
        end
    endtask

    initial begin
        logic [95:0] saved_out;
        int          saved_cnt;
        bus_if.register_load       = 1'b0;
        bus_if.register_enable     = 1'b0;
        bus_if.reg_data_in         = '0;
        bus_if.spi_transfer_length = '0;
        bus_if.lsb_first           = 1'b0;
        bus_if.launch_strobe       = 1'b0;
        bus_if.capture_strobe      = 1'b0;
        bus_if.miso                = '0;

        reset = 1'b0;
        repeat (3) tick();
        check("rst_mosi", 128'(bus_if.mosi), 128'(0));
        check("rst_out", 128'(bus_if.reg_data_out), 128'(0));
        check("rst_valid", 128'(bus_if.reg_data_out_valid), 128'(0));
        check("rst_busy", 128'(bus_if.busy), 128'(0));
        reset = 1'b1;
        tick();

        // MSB-first loopback, full 32-bit words
        run_xfer({32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF}, 5'd31, 1'b0, 1'b1, 32'h0, 1'b0, 1, 0, 0);

        // Short LSB-first with external MISO pattern
        run_xfer({3{32'hFFFF_FFA5}}, 5'd7, 1'b1, 1'b0, 32'h0000_003C, 1'b0, 1, 0, 0);
        check("mosi_seq_lsb", 128'(mosi_seq[7:0]), 128'(8'hA5));

        // Held load with strobes, then surplus edges after completion
        run_xfer({32'h0000_0C3A, 32'hFFFF_F5E1, 32'h0000_0ABC}, 5'd11, 1'b0, 1'b1, 32'h0, 1'b0, 5, 0, 0);
        saved_out = bus_if.reg_data_out;
        saved_cnt = valid_cnt;
        for (int s = 0; s < 4; s++) begin
            bus_if.miso = ~bus_if.miso;
            bus_if.capture_strobe = 1'b1;
            tick();
            bus_if.capture_strobe = 1'b0;
            bus_if.launch_strobe  = 1'b1;
            tick();
            bus_if.launch_strobe  = 1'b0;
            tick();
        end
        check("surplus_valid", 128'(valid_cnt), 128'(saved_cnt));
        check("surplus_out", 128'(bus_if.reg_data_out), 128'(saved_out));
        check("surplus_busy", 128'(bus_if.busy), 128'(0));
        check("surplus_mosi", 128'(bus_if.mosi), 128'(0));

        // Coincident launch and capture on every bit
        run_xfer({32'h0000_005A, 32'hABCD_00C3, 32'hFFFF_FF96}, 5'd7, 1'b0, 1'b1, 32'h0, 1'b1, 1, 0, 0);

        // Abort after 10 of 16 captures, then a clean LSB-first transfer
        run_xfer({32'h0000_BEEF, 32'h0000_CAFE, 32'h0000_F00D}, 5'd15, 1'b0, 1'b1, 32'h0, 1'b0, 1, 10, 1);
        run_xfer({32'h0000_1357, 32'h0000_2468, 32'h0000_9ACE}, 5'd15, 1'b1, 1'b1, 32'h0, 1'b0, 1, 0, 0);

        // Reset mid-transfer, then a clean transfer from an external pattern
        run_xfer({32'h000F_FFFF, 32'h000A_AAAA, 32'h0005_5555}, 5'd19, 1'b0, 1'b1, 32'h0, 1'b0, 1, 5, 2);
        run_xfer({3{32'h0}}, 5'd23, 1'b0, 1'b0, 32'h00AB_CDEF, 1'b0, 1, 0, 0);

        repeat (4) tick();
        check("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
